// File: rtl/imem_responder_if.sv
// Fetch-side bus between the program counter (master) and the instruction memory (slave).
// Carries the request/response handshakes plus the flush used on PC redirects.
interface imem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        output req_valid, req_addr, flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, flush, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/imem_responder.sv
// Instruction-memory responder: one outstanding fetch, fixed LATENCY, error on bad address,
// flush cancels in-flight work, side-band program port writes the array at any time.
module imem_responder #(
    parameter int          DEPTH     = 1024,
    parameter int          LATENCY   = 2,
    parameter string       INIT_FILE = "",
    parameter logic [31:0] NOP_INSN  = 32'h00000013
) (
    input  logic               clk,
    input  logic               rst,
    imem_responder_if.slave    bus,
    input  logic               prog_we,
    input  logic [31:0]        prog_addr,
    input  logic [31:0]        prog_data
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [31:0] mem [DEPTH];

    logic [1:0]  state_reg;
    logic [3:0]  cnt_reg;
    logic [31:0] rsp_data_reg;
    logic        rsp_err_reg;

    logic        req_in_range;
    logic        req_bad;
    logic        prog_in_range;
    logic        accept;
    logic        unused_prog_bits;

    // Array starts at zero.
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    end

    assign req_in_range     = (bus.req_addr[31:2] < 30'(DEPTH));
    assign req_bad          = (bus.req_addr[1:0] != 2'b00) || !req_in_range;
    assign prog_in_range    = (prog_addr[31:2] < 30'(DEPTH));
    assign unused_prog_bits = ^prog_addr[1:0];

    assign bus.req_ready = (state_reg == IDLE) && !bus.flush;
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.rsp_valid = (state_reg == RESP);
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_err   = rsp_err_reg;

    // Program writes are independent of the FSM; a same-edge fetch reads the old word.
    always_ff @(posedge clk) begin
        if (prog_we && prog_in_range) begin
            mem[prog_addr[AW+1:2]] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b0;
        end else if (bus.flush) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        rsp_err_reg  <= req_bad;
                        rsp_data_reg <= req_bad ? NOP_INSN : mem[bus.req_addr[AW+1:2]];
                        // Counter counts down to zero in WAIT, then one more edge reaches RESP.
                        cnt_reg      <= 4'(LATENCY - 1);
                        state_reg    <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: vector table of fetches plus hand-written
// sequences for backpressure, flush, program-port ordering, reset and latency sweep.
module tb_imem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_we = 1'b0;
    logic [31:0] prog_addr = '0;
    logic [31:0] prog_data = '0;

    always #5 clk = ~clk;

    imem_responder_if bus ();
    imem_responder_if bus1 ();
    imem_responder_if bus15 ();

    imem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
    );

    // Latency-sweep instances share one request stream and never get programmed.
    logic        aux_req_valid = 1'b0;
    logic [31:0] aux_req_addr  = '0;
    logic        aux_zero      = 1'b0;
    logic [31:0] aux_zero32    = '0;

    assign bus1.req_valid  = aux_req_valid;
    assign bus1.req_addr   = aux_req_addr;
    assign bus1.flush      = 1'b0;
    assign bus1.rsp_ready  = 1'b1;
    assign bus15.req_valid = aux_req_valid;
    assign bus15.req_addr  = aux_req_addr;
    assign bus15.flush     = 1'b0;
    assign bus15.rsp_ready = 1'b1;

    imem_responder #(.DEPTH(1024), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .prog_we(aux_zero), .prog_addr(aux_zero32), .prog_data(aux_zero32)
    );

    imem_responder #(.DEPTH(1024), .LATENCY(15)) dut_l15 (
        .clk(clk), .rst(rst), .bus(bus15),
        .prog_we(aux_zero), .prog_addr(aux_zero32), .prog_data(aux_zero32)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [9];
    int   errors = 0;
    int   checks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic prog(input logic [31:0] a, input logic [31:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    // Full fetch with rsp_ready=1; lat counts edges from the accept edge to rsp_valid.
    task automatic do_fetch(input logic [31:0] a, output logic [31:0] d, output logic e,
                            output int lat);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.rsp_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        d = bus.rsp_data;
        e = bus.rsp_err;
        tick();
        $display("fetch addr=%h data=%h err=%b lat=%0d", a, d, e, lat);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        int          lat;
        int          seen1;
        int          seen15;
        logic [31:0] d1;
        logic [31:0] d15;

        vecs[0] = '{32'h0000000C, 32'h00500093, 1'b0};
        vecs[1] = '{32'h0000000E, 32'h00000013, 1'b1};
        vecs[2] = '{32'h00001000, 32'h00000013, 1'b1};
        vecs[3] = '{32'h00000000, 32'h12345678, 1'b0};
        vecs[4] = '{32'h00000FFC, 32'hFEEDC0DE, 1'b0};
        vecs[5] = '{32'hFFFFFFFC, 32'h00000013, 1'b1};
        vecs[6] = '{32'h00000004, 32'h0BADF00D, 1'b0};
        vecs[7] = '{32'h00000003, 32'h00000013, 1'b1};
        vecs[8] = '{32'h80000004, 32'h00000013, 1'b1};

        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.flush     = 1'b0;
        bus.rsp_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset rsp_data", bus.rsp_data, 32'd0);
        check("reset rsp_err", 32'(bus.rsp_err), 32'd0);
        check("reset req_ready", 32'(bus.req_ready), 32'd1);

        prog(32'h00000000, 32'h12345678);
        prog(32'h00000004, 32'h0BADF00D);
        prog(32'h0000000C, 32'h00500093);
        prog(32'h00000010, 32'h11111111);
        prog(32'h00000FFC, 32'hFEEDC0DE);

        for (int i = 0; i < 9; i++) begin
            do_fetch(vecs[i].addr, d, e, lat);
            check($sformatf("vec%0d data", i), d, vecs[i].exp_data);
            check($sformatf("vec%0d err", i), 32'(e), 32'(vecs[i].exp_err));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
            check($sformatf("vec%0d ready after", i), 32'(bus.req_ready), 32'd1);
        end

        // Backpressure: response held for 5 cycles, no new request taken.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h0000000C;
        bus.rsp_ready = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        check("bp rsp_valid", 32'(bus.rsp_valid), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h00000004;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp hold%0d valid", c), 32'(bus.rsp_valid), 32'd1);
            check($sformatf("bp hold%0d data", c), bus.rsp_data, 32'h00500093);
            check($sformatf("bp hold%0d ready", c), 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        check("bp transfer valid", 32'(bus.rsp_valid), 32'd0);
        check("bp transfer ready", 32'(bus.req_ready), 32'd1);
        $display("backpressure transaction done");

        // Flush during WAIT: no response ever appears.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h00000000;
        tick();
        bus.req_valid = 1'b0;
        bus.flush     = 1'b1;
        tick();
        bus.flush = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("flush wait c%0d valid", c), 32'(bus.rsp_valid), 32'd0);
            tick();
        end
        check("flush wait ready", 32'(bus.req_ready), 32'd1);
        $display("flush-in-WAIT transaction done");

        // Flush in RESP with rsp_ready=1: response dropped.
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h00000004;
        bus.rsp_ready = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        tick();
        tick();
        check("flush resp pre valid", 32'(bus.rsp_valid), 32'd1);
        bus.flush     = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        check("flush resp ready low", 32'(bus.req_ready), 32'd0);
        tick();
        bus.flush = 1'b0;
        #1;
        check("flush resp valid", 32'(bus.rsp_valid), 32'd0);
        check("flush resp ready", 32'(bus.req_ready), 32'd1);
        $display("flush-in-RESP transaction done");

        // Flush with req_valid in IDLE: request must not be accepted.
        bus.flush     = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h00000000;
        #1;
        check("flush idle ready", 32'(bus.req_ready), 32'd0);
        tick();
        bus.flush     = 1'b0;
        bus.req_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("flush idle c%0d valid", c), 32'(bus.rsp_valid), 32'd0);
            tick();
        end
        $display("flush-in-IDLE transaction done");

        // Same-edge program write and fetch of word 4: old data returned.
        prog_we       = 1'b1;
        prog_addr     = 32'h00000010;
        prog_data     = 32'hDEADBEEF;
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h00000010;
        bus.rsp_ready = 1'b1;
        tick();
        prog_we       = 1'b0;
        bus.req_valid = 1'b0;
        tick();
        tick();
        check("same-edge valid", 32'(bus.rsp_valid), 32'd1);
        check("same-edge old data", bus.rsp_data, 32'h11111111);
        tick();
        $display("same-edge write/fetch transaction done");
        do_fetch(32'h00000010, d, e, lat);
        check("post-write data", d, 32'hDEADBEEF);
        check("post-write err", 32'(e), 32'd0);

        // Out-of-range program write is dropped, not wrapped onto word 0.
        prog(32'h00001000, 32'hBADBAD00);
        do_fetch(32'h00000000, d, e, lat);
        check("oob write dropped", d, 32'h12345678);

        // Reset during WAIT.
        prog(32'h00000014, 32'hCAFE0005);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h00000014;
        bus.rsp_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst mid valid", 32'(bus.rsp_valid), 32'd0);
        check("rst mid data", bus.rsp_data, 32'd0);
        check("rst mid err", 32'(bus.rsp_err), 32'd0);
        check("rst mid ready", 32'(bus.req_ready), 32'd1);
        tick();
        tick();
        tick();
        check("rst abandoned", 32'(bus.rsp_valid), 32'd0);
        $display("reset-in-WAIT transaction done");
        do_fetch(32'h00000014, d, e, lat);
        check("post-rst data", d, 32'hCAFE0005);
        check("post-rst latency", 32'(lat), 32'd2);
        do_fetch(32'h0000000C, d, e, lat);
        check("post-rst old array", d, 32'h00500093);

        // Latency sweep on the LATENCY=1 and LATENCY=15 instances.
        aux_req_valid = 1'b1;
        aux_req_addr  = 32'h00000008;
        tick();
        aux_req_valid = 1'b0;
        seen1  = -1;
        seen15 = -1;
        d1     = 32'hFFFFFFFF;
        d15    = 32'hFFFFFFFF;
        if (bus1.rsp_valid) seen1 = 0;
        if (bus15.rsp_valid) seen15 = 0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (bus1.rsp_valid && seen1 < 0) begin
                seen1 = c;
                d1    = bus1.rsp_data;
            end
            if (bus15.rsp_valid && seen15 < 0) begin
                seen15 = c;
                d15    = bus15.rsp_data;
            end
        end
        $display("sweep fetch lat1=%0d lat15=%0d", seen1, seen15);
        check("sweep latency 1", 32'(seen1), 32'd1);
        check("sweep latency 15", 32'(seen15), 32'd15);
        check("sweep data l1", d1, 32'd0);
        check("sweep data l15", d15, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
